// File: rtl/bsg_credit_pkg.sv
// Shared types and width helpers for the credit return batcher and its counter.
package bsg_credit_pkg;

  typedef enum logic {e_crb_idle, e_crb_send} crb_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned crb_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned CrbDefMaxStep   = 8;
  localparam int unsigned CrbDefMaxVal    = 1000;
  localparam int unsigned CrbDefStepWidth = $clog2(CrbDefMaxStep + 1);
  localparam int unsigned CrbDefValWidth  = $clog2(CrbDefMaxVal + 1);

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter: adds up_i and subtracts down_i every cycle, synchronous reset.
module bsg_counter_up_down
  import bsg_credit_pkg::*;
#(
  parameter int unsigned init_val_p = 0,
  parameter int unsigned max_val_p  = CrbDefMaxVal,
  parameter int unsigned max_step_p = CrbDefMaxStep,
  localparam int unsigned ValW      = crb_width(max_val_p),
  localparam int unsigned StepW     = crb_width(max_step_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [StepW-1:0] up_i,
  input  logic [StepW-1:0] down_i,
  output logic [ValW-1:0]  count_o
);

  logic [ValW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + ValW'(up_i) - ValW'(down_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= ValW'(init_val_p);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_credit_return_batcher.sv
// Batches receiver-freed credits into valid/ready packets of 1..max_step_p credits,
// returning early on a pending threshold, an idle timeout or an explicit flush.
module bsg_credit_return_batcher
  import bsg_credit_pkg::*;
#(
  parameter int unsigned max_step_p  = CrbDefMaxStep,
  parameter int unsigned max_val_p   = CrbDefMaxVal,
  parameter int unsigned threshold_p = 4,
  parameter int unsigned timeout_p   = 16,
  localparam int unsigned StepW      = crb_width(max_step_p),
  localparam int unsigned ValW       = crb_width(max_val_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [StepW-1:0] deq_i,
  input  logic             flush_i,
  output logic             credit_v_o,
  output logic [StepW-1:0] credit_count_o,
  input  logic             credit_ready_i,
  output logic [ValW-1:0]  outstanding_o
);

  localparam int unsigned TimerW = crb_width(timeout_p);

  localparam logic [ValW-1:0]   MaxStepV = ValW'(max_step_p);
  localparam logic [ValW-1:0]   ThreshV  = ValW'(threshold_p);
  localparam logic [TimerW-1:0] TimeoutV = TimerW'(timeout_p);

  crb_state_e        state_q, state_d;
  logic [StepW-1:0]  count_q, count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ValW-1:0]   pending;
  logic [StepW-1:0]  amt;
  logic [StepW-1:0]  down;
  logic              trigger;
  logic              fire;
  logic              load;
  logic [ValW:0]     outstanding_full;

  bsg_counter_up_down #(
    .init_val_p (0),
    .max_val_p  (max_val_p),
    .max_step_p (max_step_p)
  ) u_pending (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (deq_i),
    .down_i  (down),
    .count_o (pending)
  );

  assign amt     = (pending > MaxStepV) ? StepW'(max_step_p) : pending[StepW-1:0];
  assign trigger = (pending != '0) && ((pending >= ThreshV) || (timer_q == TimeoutV) || flush_i);
  assign fire    = credit_v_o & credit_ready_i;
  assign down    = load ? amt : '0;

  // A new packet may only be loaded when none is waiting: from idle, or on the fire cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    unique case (state_q)
      e_crb_idle: begin
        if (trigger) begin
          load    = 1'b1;
          count_d = amt;
          state_d = e_crb_send;
        end
      end
      e_crb_send: begin
        if (fire) begin
          if (trigger) begin
            load    = 1'b1;
            count_d = amt;
          end else begin
            count_d = '0;
            state_d = e_crb_idle;
          end
        end
      end
      default: state_d = e_crb_idle;
    endcase
  end

  // Keeps counting during a stalled send so a long stall flushes the remainder on reload.
  always_comb begin
    timer_d = timer_q;
    if (load || (pending == '0)) begin
      timer_d = '0;
    end else if (timer_q != TimeoutV) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_crb_idle;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  assign credit_v_o       = (state_q == e_crb_send);
  assign credit_count_o   = count_q;
  assign outstanding_full = {1'b0, pending} + (ValW + 1)'(credit_v_o ? count_q : '0);
  assign outstanding_o    = outstanding_full[ValW-1:0];

  deq_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i <= StepW'(max_step_p));

  outstanding_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
    outstanding_full <= (ValW + 1)'(max_val_p));

endmodule

// File: tb/tb_bsg_credit_return_batcher.sv
// Directed bench for bsg_credit_return_batcher at default parameters (8 / 1000 / 4 / 16).
module tb_bsg_credit_return_batcher;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] deq_i;
  logic       flush_i;
  logic       credit_v_o;
  logic [3:0] credit_count_o;
  logic       credit_ready_i;
  logic [9:0] outstanding_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bsg_credit_return_batcher dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .deq_i          (deq_i),
    .flush_i        (flush_i),
    .credit_v_o     (credit_v_o),
    .credit_count_o (credit_count_o),
    .credit_ready_i (credit_ready_i),
    .outstanding_o  (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic [3:0] deq;
    logic       flush;
    logic       ready;
    logic       exp_v;
    int         exp_cnt;
    int         exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int deq, input logic flush, input logic ready,
                     input logic v, input int cnt, input int out);
    vec_t t;
    t.rst = rst; t.deq = 4'(deq); t.flush = flush; t.ready = ready;
    t.exp_v = v; t.exp_cnt = cnt; t.exp_out = out;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int v, input int cnt, input int out);
    chk({tag, " v"}, int'(credit_v_o), v);
    chk({tag, " count"}, int'(credit_count_o), cnt);
    chk({tag, " outstanding"}, int'(outstanding_o), out);
  endtask

  // Outputs are all register-driven, so they are sampled #1 after the edge for the cycle
  // about to run; inputs for that cycle are applied at the same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int first_v;
    int first_cnt;

    reset_i = 1'b1; deq_i = '0; flush_i = 1'b0; credit_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("reset%0d", i), 0, 0, 0);
    end
    reset_i = 1'b0;

    // rst deq flush ready | v cnt out  (expected outputs during that row's cycle)
    // Single packet of 4.
    add(0, 4, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 1, 1, 4, 4);
    add(0, 0, 0, 1, 0, 0, 0);
    // Three full packets back to back.
    add(0, 8, 0, 1, 0, 0, 0);
    add(0, 8, 0, 1, 0, 0, 8);
    add(0, 8, 0, 1, 1, 8, 16);
    add(0, 0, 0, 1, 1, 8, 16);
    add(0, 0, 0, 1, 1, 8, 8);
    add(0, 0, 0, 1, 0, 0, 0);
    // Flush of a single credit below threshold.
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0);
    // Stalled packet of 5 while 3/cycle keep arriving, then drain as 5, 8, 7.
    add(0, 5, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5);
    add(0, 3, 0, 0, 1, 5, 5);
    add(0, 3, 0, 0, 1, 5, 8);
    add(0, 3, 0, 0, 1, 5, 11);
    add(0, 3, 0, 0, 1, 5, 14);
    add(0, 3, 0, 0, 1, 5, 17);
    add(0, 0, 0, 1, 1, 5, 20);
    add(0, 0, 0, 1, 1, 8, 15);
    add(0, 0, 0, 1, 1, 7, 7);
    add(0, 0, 0, 1, 0, 0, 0);
    // Reset while a packet is offered.
    add(0, 4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 1, 4, 4);
    add(0, 0, 0, 1, 0, 0, 0);
    // 3 stays below threshold; one more credit reaches it.
    add(0, 3, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 1, 1, 4, 4);
    add(0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      chk_outs($sformatf("vec%0d", i), int'(vecs[i].exp_v), vecs[i].exp_cnt, vecs[i].exp_out);
      reset_i        = vecs[i].rst;
      deq_i          = vecs[i].deq;
      flush_i        = vecs[i].flush;
      credit_ready_i = vecs[i].ready;
      tick();
    end
    reset_i = 1'b0; deq_i = '0; flush_i = 1'b0; credit_ready_i = 1'b1;

    // Timeout: 2 credits sit below threshold until the timer saturates at 16.
    chk_outs("timeout start", 0, 0, 0);
    deq_i = 4'd2;
    tick();
    deq_i = '0;
    first_v   = -1;
    first_cnt = -1;
    for (int cyc = 1; cyc <= 40 && first_v < 0; cyc++) begin
      if (cyc == 1) chk("timeout pending@1", int'(outstanding_o), 2);
      if (credit_v_o) begin
        first_v   = cyc;
        first_cnt = int'(credit_count_o);
      end
      tick();
    end
    chk("timeout first offer cycle", first_v, 18);
    chk("timeout packet count", first_cnt, 2);
    chk_outs("timeout after", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
